// File: rtl/sys_defs.sv
// Shared system definitions used by the multiply functional unit and its
// neighbours in the out-of-order core.
//   XLEN / PR_WIDTH / ROB_WIDTH : architectural and tag widths
//   MULT_FUNC                   : multiply function select
//   FU_COMPLETE_PACKET          : result packet read by the complete stage
//   MULT_STAGE_REG              : one multiplier pipeline stage register
package sys_defs;

    localparam int XLEN      = 32;
    localparam int PR_WIDTH  = 6;
    localparam int ROB_WIDTH = 5;

    typedef enum logic [1:0] {
        MUL    = 2'd0,
        MULH   = 2'd1,
        MULHSU = 2'd2,
        MULHU  = 2'd3
    } MULT_FUNC;

    typedef struct packed {
        logic [XLEN-1:0]      target_pc;
        logic [XLEN-1:0]      dest_value;
        logic [PR_WIDTH-1:0]  dest_pr;
        logic [ROB_WIDTH-1:0] rob_entry;
        logic                 if_take_branch;
    } FU_COMPLETE_PACKET;

    typedef struct packed {
        logic                 valid;
        MULT_FUNC             func;
        logic [PR_WIDTH-1:0]  dest_pr;
        logic [ROB_WIDTH-1:0] rob_entry;
        logic [63:0]          rs1;
        logic [63:0]          rs2;
        logic [63:0]          sum;
    } MULT_STAGE_REG;

endpackage

// File: rtl/mult_fu_stage.sv
// mult_stage: one partial-product stage of the multiply pipeline.
//   clock, reset : rising-edge clock, asynchronous active-high reset
//   advance      : shift enable shared by every stage
//   squash       : kill this stage's valid bit
//   stage_in     : stage register of the previous stage (or the issue slot)
//   stage_out    : this stage's register
// Stage STAGE_IDX adds rs1 * rs2[STAGE_IDX*W +: W] << (STAGE_IDX*W) to the sum.
module mult_stage
    import sys_defs::*;
#(
    parameter int unsigned NUM_STAGE = 4,
    parameter int unsigned STAGE_IDX = 0
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          advance,
    input  logic          squash,
    input  MULT_STAGE_REG stage_in,
    output MULT_STAGE_REG stage_out
);

    localparam int unsigned W     = 64 / NUM_STAGE;
    localparam int unsigned SHIFT = STAGE_IDX * W;

    logic [63:0] partial;

    // Sum is kept modulo 2^64, so the signed/unsigned treatment lives
    // entirely in the operand extension done at issue.
    always_comb begin
        partial = (stage_in.rs1 * 64'(stage_in.rs2[SHIFT +: W])) << SHIFT;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            stage_out <= '0;
        end else begin
            if (advance) begin
                stage_out     <= stage_in;
                stage_out.sum <= stage_in.sum + partial;
            end
            if (squash) begin
                stage_out.valid <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/mult_fu.sv
// mult_fu: pipelined RISC-V M-extension multiplier functional unit.
//   clock, reset          : rising-edge clock, asynchronous active-high reset
//   issue_valid/ready     : issue handshake
//   issue_func            : MUL / MULH / MULHSU / MULHU
//   rs1_value, rs2_value  : operands
//   dest_pr, rob_entry    : tags carried with the operation
//   squash                : mispredict flush of all in-flight work
//   complete_stall        : complete stage cannot take this FU's result
//   fu_finish             : a result is waiting in the last stage
//   fu_c_out              : completion register read by the complete stage
module mult_fu
    import sys_defs::*;
#(
    parameter int unsigned NUM_STAGE = 4
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 issue_valid,
    input  MULT_FUNC             issue_func,
    input  logic [XLEN-1:0]      rs1_value,
    input  logic [XLEN-1:0]      rs2_value,
    input  logic [PR_WIDTH-1:0]  dest_pr,
    input  logic [ROB_WIDTH-1:0] rob_entry,
    input  logic                 squash,
    input  logic                 complete_stall,
    output logic                 issue_ready,
    output logic                 fu_finish,
    output FU_COMPLETE_PACKET    fu_c_out
);

    MULT_STAGE_REG     stage_d [NUM_STAGE];
    MULT_STAGE_REG     stage_q [NUM_STAGE];
    FU_COMPLETE_PACKET out_q;
    logic              advance;
    logic              rs1_signed;
    logic              rs2_signed;
    logic [XLEN-1:0]   result;

    assign fu_finish   = stage_q[NUM_STAGE-1].valid;
    assign advance     = ~(fu_finish & complete_stall);
    // Reset term keeps the FU from advertising readiness while held in reset.
    assign issue_ready = advance & ~squash & ~reset;
    assign fu_c_out    = out_q;

    always_comb begin
        rs1_signed = (issue_func == MULH) || (issue_func == MULHSU);
        rs2_signed = (issue_func == MULH);

        stage_d[0]           = '0;
        stage_d[0].valid     = issue_valid & issue_ready;
        stage_d[0].func      = issue_func;
        stage_d[0].dest_pr   = dest_pr;
        stage_d[0].rob_entry = rob_entry;
        stage_d[0].rs1       = {{(64-XLEN){rs1_signed & rs1_value[XLEN-1]}}, rs1_value};
        stage_d[0].rs2       = {{(64-XLEN){rs2_signed & rs2_value[XLEN-1]}}, rs2_value};
    end

    for (genvar k = 1; k < NUM_STAGE; k++) begin : g_chain
        assign stage_d[k] = stage_q[k-1];
    end

    for (genvar k = 0; k < NUM_STAGE; k++) begin : g_stage
        mult_stage #(
            .NUM_STAGE (NUM_STAGE),
            .STAGE_IDX (k)
        ) u_stage (
            .clock     (clock),
            .reset     (reset),
            .advance   (advance),
            .squash    (squash),
            .stage_in  (stage_d[k]),
            .stage_out (stage_q[k])
        );
    end

    always_comb begin
        if (stage_q[NUM_STAGE-1].func == MUL) begin
            result = stage_q[NUM_STAGE-1].sum[31:0];
        end else begin
            result = stage_q[NUM_STAGE-1].sum[63:32];
        end
    end

    // Squash wins over a same-cycle acceptance and leaves the register as is.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            out_q <= '0;
        end else if (fu_finish & ~complete_stall & ~squash) begin
            out_q.target_pc      <= '0;
            out_q.dest_value     <= result;
            out_q.dest_pr        <= stage_q[NUM_STAGE-1].dest_pr;
            out_q.rob_entry      <= stage_q[NUM_STAGE-1].rob_entry;
            out_q.if_take_branch <= 1'b0;
        end
    end

endmodule

// File: tb/tb_mult_fu.sv
// Self-checking bench for mult_fu: directed scenarios followed by random
// traffic, all checked against an in-order age-based reference model.
module tb_mult_fu;
    import sys_defs::*;

    localparam int unsigned NS = 4;

    logic                 clock = 1'b0;
    logic                 reset = 1'b1;
    logic                 issue_valid = 1'b0;
    MULT_FUNC             issue_func = MUL;
    logic [XLEN-1:0]      rs1_value = '0;
    logic [XLEN-1:0]      rs2_value = '0;
    logic [PR_WIDTH-1:0]  dest_pr = '0;
    logic [ROB_WIDTH-1:0] rob_entry = '0;
    logic                 squash = 1'b0;
    logic                 complete_stall = 1'b0;
    logic                 issue_ready;
    logic                 fu_finish;
    FU_COMPLETE_PACKET    fu_c_out;

    mult_fu #(.NUM_STAGE(NS)) dut (
        .clock          (clock),
        .reset          (reset),
        .issue_valid    (issue_valid),
        .issue_func     (issue_func),
        .rs1_value      (rs1_value),
        .rs2_value      (rs2_value),
        .dest_pr        (dest_pr),
        .rob_entry      (rob_entry),
        .squash         (squash),
        .complete_stall (complete_stall),
        .issue_ready    (issue_ready),
        .fu_finish      (fu_finish),
        .fu_c_out       (fu_c_out)
    );

    always #5 clock = ~clock;

    typedef struct {
        int unsigned          age;
        logic [PR_WIDTH-1:0]  pr;
        logic [ROB_WIDTH-1:0] rob;
        logic [XLEN-1:0]      val;
    } ent_t;

    ent_t              q[$];
    FU_COMPLETE_PACKET exp_out = '0;
    int                checks = 0;
    int                errors = 0;
    int unsigned       tag = 0;
    logic [PR_WIDTH-1:0] last_pr;
    logic [ROB_WIDTH-1:0] last_rob;

    function automatic logic [31:0] ref_mult(MULT_FUNC f, logic [31:0] a, logic [31:0] b);
        longint sa = longint'(signed'(a));
        longint sb = longint'(signed'(b));
        longint ua = longint'({32'b0, a});
        longint ub = longint'({32'b0, b});
        logic [63:0] p;
        case (f)
            MULH:    p = sa * sb;
            MULHSU:  p = sa * ub;
            default: p = ua * ub;
        endcase
        return (f == MUL) ? p[31:0] : p[63:32];
    endfunction

    task automatic chk(input string name, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", name, obs, exp);
        end
    endtask

    // One clock cycle: drive, check against model, advance model, wait edge.
    task automatic cyc(input logic v, input MULT_FUNC f, input logic [31:0] a,
                       input logic [31:0] b, input logic st, input logic sq);
        logic fin;
        logic rdy;
        ent_t e;
        issue_valid    = v;
        issue_func     = f;
        rs1_value      = a;
        rs2_value      = b;
        dest_pr        = PR_WIDTH'(tag);
        rob_entry      = ROB_WIDTH'(tag * 3 + 1);
        complete_stall = st;
        squash         = sq;
        tag++;
        #1;
        fin = (q.size() > 0) && (q[0].age >= NS);
        rdy = !(fin && st) && !sq;
        chk("fu_finish", fu_finish, fin);
        chk("issue_ready", issue_ready, rdy);
        chk("fu_c_out", fu_c_out, exp_out);
        if (sq) begin
            q.delete();
        end else if (!(fin && st)) begin
            if (fin) begin
                e = q.pop_front();
                exp_out = '0;
                exp_out.dest_value = e.val;
                exp_out.dest_pr    = e.pr;
                exp_out.rob_entry  = e.rob;
            end
            foreach (q[i]) q[i].age++;
            if (v) begin
                e.age = 1;
                e.pr  = dest_pr;
                e.rob = rob_entry;
                e.val = ref_mult(f, a, b);
                q.push_back(e);
                last_pr  = dest_pr;
                last_rob = rob_entry;
            end
        end
        @(posedge clock);
        #1;
    endtask

    task automatic idle(input int unsigned n);
        for (int unsigned i = 0; i < n; i++) cyc(1'b0, MUL, '0, '0, 1'b0, 1'b0);
    endtask

    // Issue one op, wait for it to land in fu_c_out, compare to a literal.
    task automatic run_one(input MULT_FUNC f, input logic [31:0] a,
                           input logic [31:0] b, input logic [31:0] want, input string name);
        cyc(1'b1, f, a, b, 1'b0, 1'b0);
        idle(NS);
        chk(name, fu_c_out.dest_value, want);
    endtask

    task automatic reset_mid();
        issue_valid    = 1'b0;
        squash         = 1'b0;
        complete_stall = 1'b0;
        #2;
        reset = 1'b1;
        #1;
        chk("rst_fu_finish", fu_finish, 1'b0);
        chk("rst_fu_c_out", fu_c_out, '0);
        chk("rst_issue_ready", issue_ready, 1'b0);
        q.delete();
        exp_out = '0;
        @(posedge clock);
        #1;
        reset = 1'b0;
    endtask

    initial begin
        // Power-on reset
        #1;
        chk("por_fu_finish", fu_finish, 1'b0);
        chk("por_fu_c_out", fu_c_out, '0);
        chk("por_issue_ready", issue_ready, 1'b0);
        repeat (2) @(posedge clock);
        #1;
        reset = 1'b0;

        // MUL 7 x 6: finish in cycle 4, result visible in cycle 5
        run_one(MUL, 32'd7, 32'd6, 32'd42, "mul_7x6");
        chk("mul_7x6_pr", fu_c_out.dest_pr, last_pr);
        chk("mul_7x6_rob", fu_c_out.rob_entry, last_rob);

        // High-half corner cases
        run_one(MULH,   32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, "mulh_m1xm1");
        run_one(MULHU,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, "mulhu_max");
        run_one(MULHSU, 32'hFFFF_FFFF, 32'd2,         32'hFFFF_FFFF, "mulhsu_m1x2");
        run_one(MULH,   32'h8000_0000, 32'h8000_0000, 32'h4000_0000, "mulh_min");

        // Back-to-back issue with stall in cycles 4-6
        for (int unsigned c = 0; c < 12; c++) begin
            cyc(c < 7, MULT_FUNC'(c % 4), 32'h1234_5000 + c, 32'h9876_0000 - c,
                (c >= 4) && (c <= 6), 1'b0);
        end
        idle(NS + 8);

        // Three ops in flight, squash in cycle 2 with a same-cycle issue
        cyc(1'b1, MUL, 32'd11, 32'd13, 1'b0, 1'b0);
        cyc(1'b1, MULHU, 32'hDEAD_BEEF, 32'hCAFE_F00D, 1'b0, 1'b0);
        cyc(1'b1, MULH, 32'h8765_4321, 32'h1357_9BDF, 1'b1, 1'b1);
        idle(NS + 3);

        // Squash colliding with a stalled finished result
        cyc(1'b1, MUL, 32'd5, 32'd9, 1'b0, 1'b0);
        idle(NS - 1);
        cyc(1'b0, MUL, '0, '0, 1'b1, 1'b0);
        cyc(1'b0, MUL, '0, '0, 1'b0, 1'b1);
        idle(2);

        // Full pipeline, reset mid-cycle 3, then MUL 3 x 5
        for (int unsigned c = 0; c < 4; c++) cyc(1'b1, MULHU, 32'hF0F0_0000 + c, 32'h0F0F_FFFF, 1'b0, 1'b0);
        reset_mid();
        run_one(MUL, 32'd3, 32'd5, 32'd15, "mul_3x5_after_reset");

        // Random traffic
        for (int n = 0; n < 600; n++) begin
            logic [31:0] a;
            logic [31:0] b;
            a = ($urandom_range(0, 7) == 0) ? 32'h8000_0000 : $urandom;
            b = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFFF : $urandom;
            cyc($urandom_range(0, 9) < 7, MULT_FUNC'($urandom_range(0, 3)), a, b,
                $urandom_range(0, 9) < 3, $urandom_range(0, 49) == 0);
        end
        idle(NS + 6);
        chk("drained", q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/mult_fu.md
MULT_FU -- requirements
Module: mult_fu

Interface
REQ-001 Parameter NUM_STAGE, default 4: number of pipeline stages; legal values 2, 4, 8; each stage consumes 64/NUM_STAGE multiplier bits.
REQ-002 clock  input  1  sole clock; all state updates on its rising edge.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 issue_valid  input  1  an issued multiply is presented this cycle.
REQ-005 issue_func  input  MULT_FUNC (2)  selects MUL=0, MULH=1, MULHSU=2, MULHU=3.
REQ-006 rs1_value, rs2_value  input  `XLEN each  operands.
REQ-007 dest_pr  input  `PR  destination physical register tag.
REQ-008 rob_entry  input  `ROB  ROB index of the instruction.
REQ-009 squash  input  1  mispredict flush; kills all in-flight work.
REQ-010 complete_stall  input  1  this FU's bit of the complete stage's fu_c_stall vector.
REQ-011 issue_ready  output  1  an issue is accepted this cycle if issue_valid is high.
REQ-012 fu_finish  output  1  this FU's bit of the complete stage's fu_finish vector; a result is waiting.
REQ-013 fu_c_out  output  FU_COMPLETE_PACKET  result read by the complete stage one cycle after it selects this FU.

Function
REQ-014 Operands shall be extended to 64 bits: rs1 signed for MULH/MULHSU, unsigned otherwise; rs2 signed for MULH only, unsigned otherwise.
REQ-015 Stage k (k = 0..NUM_STAGE-1) shall add ext_rs1 * ext_rs2[k*W +: W] << (k*W), W = 64/NUM_STAGE, to the running 64-bit sum, modulo 2^64.
REQ-016 Each stage register shall carry valid, func, dest_pr, rob_entry, the extended operands and the partial sum.
REQ-017 Result: MUL gives product[31:0]; MULH, MULHSU and MULHU give product[63:32].
REQ-018 fu_finish shall equal the valid bit of the last stage.
REQ-019 advance = ~(fu_finish & complete_stall); all stages shift only when advance is high, otherwise every stage holds.
REQ-020 issue_ready = advance & ~squash; an issue is accepted when issue_valid & issue_ready.
REQ-021 Latency: an issue accepted in cycle 0 with no stall shall raise fu_finish in cycle NUM_STAGE; throughput is one issue per cycle.
REQ-022 Acceptance: fu_finish & ~complete_stall in cycle N shall load the completion register at the end of cycle N.
REQ-023 The completion register drives fu_c_out, which holds stable through cycle N+1 and until the next acceptance.
REQ-024 fu_c_out fields: dest_pr, rob_entry, dest_value = the REQ-017 result; if_take_branch = 0; target_pc = 0.
REQ-025 A stalled result shall keep fu_finish high and its data unchanged every cycle until accepted.
REQ-026 Squash in cycle N shall clear every stage valid bit at the end of cycle N.
REQ-027 A squash shall drop any issue presented in the same cycle, and shall override a simultaneous acceptance of the last stage.
REQ-028 Squash shall leave the completion register unchanged; the ROB discards it.
REQ-029 complete_stall sampled while fu_finish is low shall have no effect.

Reset
REQ-030 Asserting reset, at any time including mid-operation, shall immediately clear all stage valid bits and the completion register to zero.
REQ-031 During reset fu_finish = 0, fu_c_out = all zeros and issue_ready = 0.
REQ-032 The first issue is accepted in the first cycle after reset deassertion.

Structure
REQ-033 MULT_FUNC enum, FU_COMPLETE_PACKET, `XLEN, `PR and `ROB shall come from the shared sys_defs package.
REQ-034 One sub-module, mult_stage, shall implement a single partial-product stage and be instantiated NUM_STAGE times.

Verification
REQ-035 MUL 7 x 6 issued cycle 0 -> fu_finish in cycle 4; cycle 5 fu_c_out.dest_value = 42 with matching dest_pr and rob_entry.
REQ-036 MULH 0xFFFFFFFF x 0xFFFFFFFF -> 0x00000000; MULHU same operands -> 0xFFFFFFFE; MULHSU 0xFFFFFFFF x 2 -> 0xFFFFFFFF.
REQ-037 Back-to-back issues, complete_stall high in cycles 4-6 -> fu_finish held, issue_ready low in cycles 4-6, no packet lost, results in issue order.
REQ-038 Squash in cycle 2 with three ops in flight and a same-cycle issue -> fu_finish never rises for them; fu_c_out unchanged.
REQ-039 Reset asserted mid-cycle 3 with a full pipeline -> fu_finish = 0 and fu_c_out = 0 immediately; a new MUL 3 x 5 after release -> 15.
